// File: rtl/vc_route_ctrl.sv
// rtl/vc_route_ctrl.sv - main FIFO pop controller and VC0/VC1 router
// Pops the main FIFO, steers each word by its top bit, sequences FIFO init and reports status.
module vc_route_ctrl #(
  parameter int data_width = 6,
  parameter int cnt_width  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init_in,
  input  logic [cnt_width-1:0]  umbral_main_in,
  input  logic [cnt_width-1:0]  umbral_vc_in,
  input  logic                  main_empty,
  input  logic [data_width-1:0] main_data,
  input  logic                  main_error,
  input  logic                  vc0_almost_full,
  input  logic                  vc1_almost_full,
  input  logic                  vc0_empty,
  input  logic                  vc1_empty,
  input  logic                  vc0_error,
  input  logic                  vc1_error,
  output logic                  fifo_init,
  output logic [cnt_width-1:0]  umbral_main_out,
  output logic [cnt_width-1:0]  umbral_vc_out,
  output logic                  main_rd_en,
  output logic                  vc0_wr_en,
  output logic                  vc1_wr_en,
  output logic [data_width-1:0] vc_data,
  output logic [2:0]            state,
  output logic                  idle_out,
  output logic                  error_out
);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_INIT   = 3'd1,
    S_IDLE   = 3'd2,
    S_ACTIVE = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  state_t cur_state;
  state_t nxt_state;
  logic   in_flight;
  logic   run_cur;
  logic   run_nxt;

  assign state   = cur_state;
  assign run_cur = (cur_state == S_IDLE) || (cur_state == S_ACTIVE);
  assign run_nxt = (nxt_state == S_IDLE) || (nxt_state == S_ACTIVE);

  always_comb begin
    nxt_state = cur_state;
    if (cur_state == S_RESET) begin
      nxt_state = S_INIT;
    end else if (init_in) begin
      nxt_state = S_INIT;
    end else if (main_error || vc0_error || vc1_error) begin
      nxt_state = S_ERROR;
    end else begin
      case (cur_state)
        S_INIT:   nxt_state = S_IDLE;
        S_IDLE:   if (!main_empty) nxt_state = S_ACTIVE;
        S_ACTIVE: if (main_empty && !in_flight && vc0_empty && vc1_empty) nxt_state = S_IDLE;
        default:  nxt_state = cur_state;
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cur_state       <= S_RESET;
      fifo_init       <= 1'b0;
      main_rd_en      <= 1'b0;
      vc0_wr_en       <= 1'b0;
      vc1_wr_en       <= 1'b0;
      vc_data         <= '0;
      umbral_main_out <= '0;
      umbral_vc_out   <= '0;
      idle_out        <= 1'b0;
      error_out       <= 1'b0;
      in_flight       <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      fifo_init <= run_nxt || (nxt_state == S_ERROR);
      idle_out  <= (nxt_state == S_IDLE);
      if (nxt_state == S_ERROR) begin
        error_out <= 1'b1;
      end else if (nxt_state == S_INIT) begin
        error_out <= 1'b0;
      end
      if (cur_state == S_INIT) begin
        umbral_main_out <= umbral_main_in;
        umbral_vc_out   <= umbral_vc_in;
      end
      // Destination is unknown before the read, so either almost_full stalls the pop.
      main_rd_en <= run_cur && run_nxt && !main_empty && !vc0_almost_full && !vc1_almost_full;
      in_flight  <= main_rd_en && run_nxt;
      vc0_wr_en  <= in_flight && run_nxt && !main_data[data_width-1];
      vc1_wr_en  <= in_flight && run_nxt && main_data[data_width-1];
      if (in_flight && run_nxt) begin
        vc_data <= main_data;
      end
    end
  end

endmodule

// File: tb/tb_vc_route_ctrl.sv
// tb/tb_vc_route_ctrl.sv - scoreboard bench for vc_route_ctrl
module tb_vc_route_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       init_in;
  logic [3:0] umbral_main_in;
  logic [3:0] umbral_vc_in;
  logic       main_empty;
  logic [5:0] main_data = '0;
  logic       main_error;
  logic       vc0_almost_full;
  logic       vc1_almost_full;
  logic       vc0_empty;
  logic       vc1_empty;
  logic       vc0_error;
  logic       vc1_error;
  logic       fifo_init;
  logic [3:0] umbral_main_out;
  logic [3:0] umbral_vc_out;
  logic       main_rd_en;
  logic       vc0_wr_en;
  logic       vc1_wr_en;
  logic [5:0] vc_data;
  logic [2:0] state;
  logic       idle_out;
  logic       error_out;

  int checks = 0;
  int failures = 0;
  int exp_q[$];
  logic [5:0] mem [16];
  int head = 0;
  int tail = 0;

  vc_route_ctrl #(.data_width(6), .cnt_width(4)) dut (
    .clk(clk), .reset(reset), .init_in(init_in),
    .umbral_main_in(umbral_main_in), .umbral_vc_in(umbral_vc_in),
    .main_empty(main_empty), .main_data(main_data), .main_error(main_error),
    .vc0_almost_full(vc0_almost_full), .vc1_almost_full(vc1_almost_full),
    .vc0_empty(vc0_empty), .vc1_empty(vc1_empty),
    .vc0_error(vc0_error), .vc1_error(vc1_error),
    .fifo_init(fifo_init), .umbral_main_out(umbral_main_out), .umbral_vc_out(umbral_vc_out),
    .main_rd_en(main_rd_en), .vc0_wr_en(vc0_wr_en), .vc1_wr_en(vc1_wr_en),
    .vc_data(vc_data), .state(state), .idle_out(idle_out), .error_out(error_out)
  );

  always #5 clk = ~clk;

  // Main FIFO model: empty already accounts for the pop being issued this cycle.
  always_comb main_empty = ((tail - head) - (main_rd_en ? 1 : 0)) <= 0;

  always @(posedge clk) begin
    if (main_rd_en && (head != tail)) begin
      main_data <= mem[head % 16];
      head <= head + 1;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [5:0] w, input bit expect_write);
    mem[tail % 16] = w;
    tail = tail + 1;
    if (expect_write) exp_q.push_back({25'd0, w[5], w});
  endtask

  task automatic wait_drained(input string name);
    int n = 0;
    while (!(state == 3'd2 && exp_q.size() == 0) && n < 30) begin
      tick();
      n++;
    end
    check(name, (state == 3'd2 && exp_q.size() == 0) ? 1 : 0, 1);
  endtask

  always @(negedge clk) begin
    if (vc0_wr_en || vc1_wr_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got data %0d wr0 %0d wr1 %0d expected no write",
                 vc_data, vc0_wr_en, vc1_wr_en);
      end else begin
        int e;
        e = exp_q.pop_front();
        check("route_word", {vc1_wr_en, vc0_wr_en, vc_data},
              {e[6], ~e[6], e[5:0]});
      end
    end
  end

  initial begin
    reset = 1'b0; init_in = 1'b1; umbral_main_in = 4'd2; umbral_vc_in = 4'd1;
    main_error = 1'b0; vc0_error = 1'b0; vc1_error = 1'b0;
    vc0_almost_full = 1'b0; vc1_almost_full = 1'b0; vc0_empty = 1'b1; vc1_empty = 1'b1;

    // Reset values, then the init sequence.
    tick(); tick();
    check("rst_state", state, 0);
    check("rst_fifo_init", fifo_init, 0);
    check("rst_rd_en", main_rd_en, 0);
    check("rst_wr", {vc1_wr_en, vc0_wr_en}, 0);
    check("rst_umbral", {umbral_main_out, umbral_vc_out}, 0);
    check("rst_flags", {idle_out, error_out}, 0);
    reset = 1'b1;
    tick();
    check("init_state", state, 1);
    tick();
    check("umbral_main", umbral_main_out, 2);
    check("umbral_vc", umbral_vc_out, 1);
    tick();
    init_in = 1'b0;
    #3;
    check("fifo_init_low", fifo_init, 0);
    tick();
    check("idle_state", state, 2);
    check("fifo_init_high", fifo_init, 1);
    check("idle_out", idle_out, 1);

    // Two words, one per VC.
    push_word(6'h05, 1'b1);
    push_word(6'h25, 1'b1);
    tick();
    check("t2_active", state, 3);
    check("t2_rd_n", main_rd_en, 1);
    tick();
    check("t2_rd_n1", main_rd_en, 1);
    tick();
    check("t2_rd_n2", main_rd_en, 0);
    check("t2_wr0_n2", vc0_wr_en, 1);
    check("t2_data_n2", vc_data, 6'h05);
    tick();
    check("t2_wr1_n3", vc1_wr_en, 1);
    check("t2_state_n3", state, 3);
    tick();
    check("t2_back_idle", state, 2);

    // Backpressure mid-stream.
    push_word(6'h11, 1'b1);
    push_word(6'h3A, 1'b1);
    push_word(6'h02, 1'b1);
    push_word(6'h20, 1'b1);
    tick();
    check("t3_rd_n", main_rd_en, 1);
    vc1_almost_full = 1'b1;
    tick();
    check("t3_rd_n1", main_rd_en, 0);
    tick();
    check("t3_rd_n2", main_rd_en, 0);
    check("t3_wr0_n2", vc0_wr_en, 1);
    tick();
    check("t3_hold_n3", {main_rd_en, vc1_wr_en, vc0_wr_en}, 0);
    tick();
    check("t3_hold_n4", {main_rd_en, vc1_wr_en, vc0_wr_en}, 0);
    check("t3_state", state, 3);
    vc1_almost_full = 1'b0;
    wait_drained("t3_drain");

    // Error during traffic; the in-flight word is dropped.
    push_word(6'h01, 1'b0);
    push_word(6'h03, 1'b0);
    push_word(6'h07, 1'b0);
    tick();
    check("t4_rd_n", main_rd_en, 1);
    tick();
    vc0_error = 1'b1;
    tick();
    vc0_error = 1'b0;
    check("t4_err_state", state, 4);
    check("t4_err_out", error_out, 1);
    check("t4_enables", {main_rd_en, vc1_wr_en, vc0_wr_en}, 0);
    check("t4_fifo_init", fifo_init, 1);
    tick(); tick();
    check("t4_sticky_state", state, 4);
    check("t4_sticky_err", error_out, 1);
    check("t4_sticky_rd", main_rd_en, 0);
    init_in = 1'b1;
    tick();
    init_in = 1'b0;
    check("t4_init_state", state, 1);
    check("t4_err_clear", error_out, 0);
    exp_q.push_back({25'd0, 1'b0, 6'h07});
    wait_drained("t4_drain");

    // Reset with a word in flight.
    push_word(6'h2C, 1'b0);
    push_word(6'h0F, 1'b0);
    tick();
    check("t5_rd_n", main_rd_en, 1);
    tick();
    reset = 1'b0;
    tick();
    check("t5_state", state, 0);
    check("t5_enables", {main_rd_en, vc1_wr_en, vc0_wr_en}, 0);
    check("t5_vc_data", vc_data, 0);
    check("t5_misc", {fifo_init, idle_out, error_out}, 0);
    check("t5_umbral", {umbral_main_out, umbral_vc_out}, 0);
    tick();
    check("t5_no_wr", {vc1_wr_en, vc0_wr_en}, 0);
    reset = 1'b1;
    tick();
    check("t5_init", state, 1);
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
